// File: rtl/ega_video_conditioner.sv
// EGA/CGA RGBI conditioner: sync filtering, line/frame timing, hysteretic mode
// detection with sync acquisition, per-mode colour remap, blanking and composite sync.
module ega_video_conditioner #(
  parameter int               CW         = 2,
  parameter int               SYNC_FILT  = 8,
  parameter int               HCNT_W     = 16,
  parameter int               VCNT_W     = 32,
  parameter int               ACC_W      = 24,
  parameter logic [ACC_W-1:0] MODE_THR   = 24'h500000,
  parameter logic [ACC_W-1:0] MODE_HYS   = 24'h010000,
  parameter int               ACQ_FRAMES = 2,
  parameter int               HB_START   = 500,
  parameter int               HB_END     = 2950,
  parameter int               VB_START   = 89700,
  parameter int               VB_END     = 780000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     r_in,
  input  logic [CW-1:0]     g_in,
  input  logic [CW-1:0]     b_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [CW-1:0]     r_out,
  output logic [CW-1:0]     g_out,
  output logic [CW-1:0]     b_out,
  output logic              csync,
  output logic              mode,
  output logic              mode_valid,
  output logic [HCNT_W-1:0] hs_period,
  output logic [2:0]        led
);

  localparam int ECW = $clog2(ACQ_FRAMES + 1);
  localparam logic [ECW-1:0]    ACQ_N = ECW'(ACQ_FRAMES);
  localparam logic [HCNT_W-1:0] HB_S  = HCNT_W'(HB_START);
  localparam logic [HCNT_W-1:0] HB_E  = HCNT_W'(HB_END);
  localparam logic [VCNT_W-1:0] VB_S  = VCNT_W'(VB_START);
  localparam logic [VCNT_W-1:0] VB_E  = VCNT_W'(VB_END);
  // Upper bound carries one extra bit so THR+HYS cannot wrap.
  localparam logic [ACC_W:0]    THR_HI = {1'b0, MODE_THR} + {1'b0, MODE_HYS};
  localparam logic [ACC_W-1:0]  THR_LO = MODE_THR - MODE_HYS;

  typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [SYNC_FILT-1:0]  hs_sr, vs_sr;
  logic [HCNT_W-1:0]     hcnt;
  logic [VCNT_W-1:0]     vcnt;
  logic [ACC_W-1:0]      acc;
  logic [ECW-1:0]        vedges;
  logic                  h_edge, v_edge, vcnt_sat;
  logic                  lock_now, edge_inc, edge_clr;
  logic                  hd, vd, gate, keep;
  logic [CW-1:0]         r1, g1, b1;
  logic [CW-1:0]         r_m, g_m, b_m;

  // A clean rising edge: two old samples low, two newest samples high.
  assign h_edge   = (hs_sr[SYNC_FILT-1 -: 2] == 2'b00) && (hs_sr[1:0] == 2'b11);
  assign v_edge   = (vs_sr[SYNC_FILT-1 -: 2] == 2'b00) && (vs_sr[1:0] == 2'b11);
  assign vcnt_sat = (vcnt == '1);
  assign led      = {mode_valid, mode, mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sr     <= '0;
      vs_sr     <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      hs_period <= '0;
      acc       <= '0;
      mode      <= 1'b0;
    end else begin
      hs_sr <= {hs_sr[SYNC_FILT-2:0], hs_in};
      vs_sr <= {vs_sr[SYNC_FILT-2:0], vs_in};
      if (h_edge)          hcnt <= '0;
      else if (hcnt != '1) hcnt <= hcnt + 1'b1;
      if (v_edge)          vcnt <= '0;
      else if (!vcnt_sat)  vcnt <= vcnt + 1'b1;
      if (h_edge) hs_period <= hcnt;
      if (vs_sr[0]) begin
        if (acc != '1) acc <= acc + 1'b1;
      end else if (acc != '0) begin
        acc <= acc - 1'b1;
      end
      if ({1'b0, acc} > THR_HI) mode <= 1'b0;
      else if (acc < THR_LO)    mode <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACQ:  if (vedges >= ACQ_N) state_nxt = LOCK;
      LOCK: if (vcnt_sat)        state_nxt = ACQ;
      default: state_nxt = ACQ;
    endcase
  end

  always_comb begin
    lock_now = (state == LOCK);
    edge_inc = (state == ACQ) && v_edge && (vedges != '1);
    edge_clr = (state == LOCK) && vcnt_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vedges     <= '0;
      mode_valid <= 1'b0;
    end else begin
      if (edge_clr)      vedges <= '0;
      else if (edge_inc) vedges <= vedges + 1'b1;
      mode_valid <= lock_now;
    end
  end

  // Stage 1 captures raw colour and the visible-window flags for the same hcnt/vcnt.
  always_comb begin
    r_m = r1;
    g_m = g1;
    b_m = b1;
    if (mode) begin
      r_m[0] = g1[0];
      b_m[0] = g1[0];
      if ((g1[1:0] == 2'b10) && r1[CW-1] && !b1[CW-1]) g_m[1:0] = 2'b01;
    end
    gate = mode ? (hd & vd) : 1'b1;
    keep = gate & mode_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1    <= '0;
      g1    <= '0;
      b1    <= '0;
      hd    <= 1'b0;
      vd    <= 1'b0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      csync <= 1'b1;
    end else begin
      r1    <= r_in;
      g1    <= g_in;
      b1    <= b_in;
      hd    <= (hcnt >= HB_S) && (hcnt <= HB_E);
      vd    <= (vcnt >= VB_S) && (vcnt <= VB_E);
      r_out <= {CW{keep}} & r_m;
      g_out <= {CW{keep}} & g_m;
      b_out <= {CW{keep}} & b_m;
      if (!mode_valid) csync <= 1'b1;
      else if (mode)   csync <= ~(hs_sr[0] ^ vs_sr[0]);
      else             csync <= hs_sr[0] ^ vs_sr[0];
    end
  end

endmodule

// File: tb/tb_ega_video_conditioner.sv
// Directed bench for ega_video_conditioner with scaled timing parameters and a
// latency-2 scoreboard on {csync, r, g, b}.
module tb_ega_video_conditioner;
  localparam int CW      = 2;
  localparam int H_LEN   = 3000;
  localparam int H_PULSE = 200;
  localparam int HB_S    = 500;
  localparam int HB_E    = 2950;
  localparam int VB_S    = 2;
  localparam int VB_E    = 16000;
  localparam int VMAX    = 16383;
  // Steps from a sync rise until the counter a pixel is judged against reads 0.
  localparam int LAT_CNT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_in = 1'b0, vs_in = 1'b0;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          csync, mode, mode_valid;
  logic [11:0]   hs_period;
  logic [2:0]    led;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  logic [3*CW:0] exp_q[$];
  bit            chk_q[$];

  int  h_pos = H_LEN - 1;
  int  v_pos = 0;
  int  vp = 0;
  int  v_len = 3000;
  int  vs_mode = 0;
  bit  h_on = 0, h_started = 0, h_ok = 0, v_started = 0, v_ok = 0;
  bit  m_mode = 0, m_valid = 0, chk_en = 1, rand_col = 1;
  logic [CW-1:0] cr = '0, cg = '0, cb = '0;

  ega_video_conditioner #(
    .CW(2), .SYNC_FILT(4), .HCNT_W(12), .VCNT_W(14), .ACC_W(12),
    .MODE_THR(12'h500), .MODE_HYS(12'h010), .ACQ_FRAMES(2),
    .HB_START(HB_S), .HB_END(HB_E), .VB_START(VB_S), .VB_END(VB_E)
  ) dut (
    .clk(clk), .rst(rst),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .csync(csync), .mode(mode), .mode_valid(mode_valid),
    .hs_period(hs_period), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare the output due now, then drive and score the next input.
  task automatic step();
    logic [3*CW:0] e, got;
    logic [CW-1:0] er, eg, eb;
    logic          cs;
    bit            c, nh, nv, gate;
    int            hseen, vseen;
    @(negedge clk);
    t++;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      got = {csync, r_out, g_out, b_out};
      if (c) check($sformatf("pix t=%0d", t), 32'(got), 32'(e));
    end
    if (h_on) begin
      h_pos = (h_pos + 1) % H_LEN;
      if (h_pos == 0) h_started = 1;
      if (h_started && h_pos == LAT_CNT) h_ok = 1;
    end
    nh = h_on && (h_pos < H_PULSE);
    vp++;
    case (vs_mode)
      0:       nv = 0;
      1:       nv = 1;
      default: nv = ((vp % v_len) < 4);
    endcase
    if (nv && !vs_in) begin
      v_pos = 0;
      v_started = 1;
    end else begin
      v_pos++;
    end
    if (v_started && v_pos == LAT_CNT) v_ok = 1;
    hseen = (h_pos >= LAT_CNT) ? h_pos - LAT_CNT : h_pos + H_LEN - LAT_CNT;
    vseen = v_pos - LAT_CNT;
    if (vseen > VMAX) vseen = VMAX;
    if (rand_col) begin
      cr = CW'($urandom_range(0, 3));
      cg = CW'($urandom_range(0, 3));
      cb = CW'($urandom_range(0, 3));
      if (m_mode && h_ok && (hseen == HB_S - 1 || hseen == HB_S || hseen == HB_E || hseen == HB_E + 1)) begin
        cr = '1;
        cg = '1;
        cb = '1;
      end
    end
    gate = !m_mode || ((hseen >= HB_S) && (hseen <= HB_E) && (vseen >= VB_S) && (vseen <= VB_E));
    er = cr;
    eg = cg;
    eb = cb;
    if (m_mode) begin
      er[0] = cg[0];
      eb[0] = cg[0];
      if (cg[1:0] == 2'b10 && cr[CW-1] && !cb[CW-1]) eg[1:0] = 2'b01;
    end
    if (!(gate && m_valid)) begin
      er = '0;
      eg = '0;
      eb = '0;
    end
    if (!m_valid)    cs = 1'b1;
    else if (m_mode) cs = ~(nh ^ nv);
    else             cs = nh ^ nv;
    c = chk_en && (!m_valid || !m_mode || (h_ok && v_ok && v_pos >= LAT_CNT));
    exp_q.push_back({cs, er, eg, eb});
    chk_q.push_back(c);
    r_in  = cr;
    g_in  = cg;
    b_in  = cb;
    hs_in = nh;
    vs_in = nv;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset with quiet syncs.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst r_out", 32'(r_out), 0);
    check("rst g_out", 32'(g_out), 0);
    check("rst b_out", 32'(b_out), 0);
    check("rst csync", 32'(csync), 1);
    check("rst mode", 32'(mode), 0);
    check("rst mode_valid", 32'(mode_valid), 0);
    check("rst hs_period", 32'(hs_period), 0);
    check("rst led", 32'(led), 0);
    rst = 1'b0;
    run(40);
    check("idle mode_valid", 32'(mode_valid), 0);
    check("idle mode (acc=0)", 32'(mode), 1);
    check("idle csync", 32'(csync), 1);

    // Long vsync pulses: acquire lock in pass-through mode.
    chk_en = 0;
    h_on = 1;
    vs_mode = 1;
    run(1400);
    vs_mode = 0;
    run(10);
    vs_mode = 1;
    run(100);
    check("lock mode_valid", 32'(mode_valid), 1);
    check("lock mode", 32'(mode), 0);
    check("lock led", 32'(led), 3'b100);
    m_valid = 1;
    m_mode = 0;
    chk_en = 1;
    run(1700);
    check("hs_period", 32'(hs_period), 2999);

    // Short vsync pulses drain the accumulator into remap/blank mode.
    chk_en = 0;
    vs_mode = 2;
    vp = 3;
    run(2500);
    check("mode1 mode", 32'(mode), 1);
    check("mode1 led", 32'(led), 3'b111);
    check("mode1 mode_valid", 32'(mode_valid), 1);
    m_mode = 1;
    chk_en = 1;
    run(3000);
    rand_col = 0;
    cr = 2'b10;
    cg = 2'b10;
    cb = 2'b00;
    run(10);
    check("brown g_out", 32'(g_out), 2'b01);
    check("brown r_out", 32'(r_out), 2'b10);
    check("brown b_out", 32'(b_out), 2'b00);
    rand_col = 1;

    // Accumulator wobbling inside the hysteresis band must not flip mode.
    chk_en = 0;
    vs_mode = 0;
    run(20);
    vs_mode = 1;
    run(1280);
    check("hys mid mode", 32'(mode), 1);
    vs_mode = 0;
    run(8);
    for (int i = 0; i < 6; i++) begin
      vs_mode = 1;
      run(16);
      check("hys band hi m1", 32'(mode), 1);
      vs_mode = 0;
      run(16);
      check("hys band lo m1", 32'(mode), 1);
    end
    vs_mode = 1;
    run(128);
    check("hys cross up", 32'(mode), 0);
    vs_mode = 0;
    run(112);
    for (int i = 0; i < 6; i++) begin
      vs_mode = 0;
      run(16);
      check("hys band lo m0", 32'(mode), 0);
      vs_mode = 1;
      run(16);
      check("hys band hi m0", 32'(mode), 0);
    end

    // Lose vsync: vcnt saturates and lock drops.
    vs_mode = 0;
    run(15000);
    check("presat mode_valid", 32'(mode_valid), 1);
    run(1500);
    check("sat mode_valid", 32'(mode_valid), 0);
    check("sat led", 32'(led), 3'b011);
    m_valid = 0;
    m_mode = 1;
    chk_en = 1;
    run(40);
    check("sat csync", 32'(csync), 1);

    // Reset mid-line clears everything immediately.
    check("prerst hs_period", 32'(hs_period), 2999);
    rst = 1'b1;
    #1;
    check("midrst hs_period", 32'(hs_period), 0);
    check("midrst r_out", 32'(r_out), 0);
    check("midrst csync", 32'(csync), 1);
    check("midrst mode_valid", 32'(mode_valid), 0);
    check("midrst led", 32'(led), 0);
    exp_q.delete();
    chk_q.delete();
    h_ok = 0;
    h_started = 0;
    v_ok = 0;
    v_started = 0;
    run(5);
    rst = 1'b0;
    run(20);
    check("postrst mode_valid", 32'(mode_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
